// File: rtl/fifo_wr_arb_if.sv
`default_nettype none
// =============================================================================
// fifo_wr_arb_if : requester/FIFO-side bundle of the FIFO write arbiter. Rev 1.0
// =============================================================================
interface fifo_wr_arb_if #(
  parameter int WIDTH = 8,
  parameter int PTR   = 4
);
  logic [3:0]             req;
  logic [4*(PTR+1)-1:0]   req_len;
  logic [4*WIDTH-1:0]     req_data;
  logic [3:0]             gnt;
  logic [3:0]             ack;
  logic                   wren;
  logic [WIDTH-1:0]       datain;
  logic                   wrfull;
  logic [PTR:0]           wrusedw;
  logic [1:0]             owner;
  logic                   busy;
  logic [3:0]             err_len;
  logic                   abort;

  modport master (
    output req, req_len, req_data, wrfull, wrusedw,
    input  gnt, ack, wren, datain, owner, busy, err_len, abort
  );

  modport slave (
    input  req, req_len, req_data, wrfull, wrusedw,
    output gnt, ack, wren, datain, owner, busy, err_len, abort
  );
endinterface
`default_nettype wire

// File: rtl/fifo_wr_arb.sv
`default_nettype none
// =============================================================================
// fifo_wr_arb : four-requester round-robin arbiter for a FIFO write port. Rev 1.0
// =============================================================================
module fifo_wr_arb #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int PTR   = 4
) (
  input wire          clk,
  input wire          reset_,
  fifo_wr_arb_if.slave bus
);

  localparam logic [PTR:0] c_depth = (PTR+1)'(DEPTH);
  localparam logic [PTR:0] c_one   = (PTR+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_SPACE = 2'd1,
    S_XFER       = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [1:0]   r_owner;
  logic [1:0]   w_owner_nxt;
  logic [1:0]   r_last_owner;
  logic [1:0]   w_last_nxt;
  logic [PTR:0] r_rem;
  logic [PTR:0] w_rem_nxt;

  logic [PTR:0]     w_len [4];
  logic [WIDTH-1:0] w_dat [4];
  logic [3:0]       w_len_ok;
  logic [3:0]       w_elig;
  logic             w_found;
  logic [1:0]       w_win;
  logic [PTR:0]     w_space;
  logic             w_room;
  logic             w_wren;
  logic             w_abort;
  logic             w_busy;
  logic [3:0]       w_gnt;

  for (genvar gi = 0; gi < 4; gi++) begin : g_req
    assign w_len[gi]    = bus.req_len[gi*(PTR+1) +: (PTR+1)];
    assign w_dat[gi]    = bus.req_data[gi*WIDTH +: WIDTH];
    assign w_len_ok[gi] = (w_len[gi] != '0) && (w_len[gi] <= c_depth);
  end

  assign w_elig = bus.req & w_len_ok;

  // Search starts one past the last owner so a returning requester queues last.
  always_comb begin : p_rr
    logic [1:0] cand;
    w_found = 1'b0;
    w_win   = 2'd0;
    cand    = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = r_last_owner + 2'(k);
      if (!w_found && w_elig[cand]) begin
        w_found = 1'b1;
        w_win   = cand;
      end
    end
  end

  assign w_space = c_depth - bus.wrusedw;
  assign w_room  = (bus.wrusedw <= c_depth) && (w_space >= r_rem) && !bus.wrfull;

  always_comb begin : p_fsm
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last_owner;
    w_rem_nxt   = r_rem;
    w_wren      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_owner_nxt = w_win;
          w_rem_nxt   = w_len[w_win];
          w_state_nxt = S_WAIT_SPACE;
        end
      end
      S_WAIT_SPACE: begin
        if (!bus.req[r_owner]) begin
          w_state_nxt = S_IDLE;
        end else if (w_room) begin
          w_state_nxt = S_XFER;
        end
      end
      S_XFER: begin
        if (!bus.req[r_owner]) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
          w_last_nxt  = r_owner;
        end else if (!bus.wrfull) begin
          w_wren    = 1'b1;
          w_rem_nxt = r_rem - c_one;
          if (r_rem == c_one) begin
            w_state_nxt = S_IDLE;
            w_last_nxt  = r_owner;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Last owner resets to 3 so requester 0 is searched first.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state      <= S_IDLE;
      r_owner      <= 2'd0;
      r_last_owner <= 2'd3;
      r_rem        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_nxt;
      r_rem        <= w_rem_nxt;
    end
  end

  assign w_busy = (r_state != S_IDLE);
  assign w_gnt  = w_busy ? (4'b0001 << r_owner) : 4'b0000;

  assign bus.gnt     = w_gnt;
  assign bus.ack     = w_wren ? w_gnt : 4'b0000;
  assign bus.wren    = w_wren;
  assign bus.datain  = w_busy ? w_dat[r_owner] : '0;
  assign bus.owner   = r_owner;
  assign bus.busy    = w_busy;
  assign bus.err_len = bus.req & ~w_len_ok;
  assign bus.abort   = w_abort;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arb.sv
`default_nettype none
// =============================================================================
// tb_fifo_wr_arb : directed, table-driven bench for fifo_wr_arb. Rev 1.0
// =============================================================================
module tb_fifo_wr_arb;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int PTR   = 4;

  logic clk = 1'b0;
  logic reset_;
  always #5 clk = ~clk;

  fifo_wr_arb_if #(.WIDTH(WIDTH), .PTR(PTR)) bif ();

  fifo_wr_arb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR(PTR)) dut (
    .clk   (clk),
    .reset_(reset_),
    .bus   (bif)
  );

  typedef struct {
    logic [3:0]  req;
    logic [19:0] len;
    logic [3:0]  err;
  } errvec_t;

  typedef struct {
    logic [3:0] gnt;
    logic [3:0] ack;
    logic       wren;
    logic       busy;
    logic [7:0] data;
  } trace_t;

  errvec_t ev [5];
  trace_t  tr [16];

  int n_tests = 0;
  int n_fail  = 0;
  int n_wr    = 0;
  int n_ab    = 0;
  int n_stall = 0;
  int stalled = 0;
  int left [4];
  logic [3:0] drop;
  logic       pend_full;
  logic       saw_bad;

  logic [3:0] s_gnt, s_ack;
  logic       s_wren, s_busy, s_abort;
  logic [7:0] s_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_len(input int i, input logic [4:0] v);
    bif.req_len[i*5 +: 5] = v;
  endtask

  task automatic set_tr(input int k, input logic [3:0] g, input logic [3:0] a,
                        input logic w, input logic b, input logic [7:0] d);
    tr[k].gnt = g; tr[k].ack = a; tr[k].wren = w; tr[k].busy = b; tr[k].data = d;
  endtask

  // Requesters drop req and the FIFO updates wrfull just after the edge that commits a word.
  task automatic step();
    logic ok;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (drop[i]) begin
        bif.req[i] = 1'b0;
        drop[i]    = 1'b0;
      end
    end
    bif.wrfull = pend_full;
    @(negedge clk);
    s_gnt   = bif.gnt;
    s_ack   = bif.ack;
    s_wren  = bif.wren;
    s_busy  = bif.busy;
    s_abort = bif.abort;
    s_data  = bif.datain;
    if (s_wren) n_wr++;
    if (s_abort) n_ab++;
    for (int i = 0; i < 4; i++) begin
      if (s_ack[i] && left[i] > 0) begin
        left[i]--;
        if (left[i] == 0) drop[i] = 1'b1;
      end
    end
    ok = (s_ack == (s_wren ? s_gnt : 4'b0000)) && ($countones(s_gnt) <= 1) &&
         (s_busy || (s_gnt == 4'b0000 && !s_wren));
    check("invariant", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int c;
    c = 0;
    while (s_busy && c < budget) begin
      step();
      c++;
    end
    check({name, "_done"}, {31'd0, s_busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_       = 1'b0;
    bif.req      = 4'b0000;
    bif.req_len  = '0;
    bif.req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    bif.wrfull   = 1'b0;
    bif.wrusedw  = '0;
    pend_full    = 1'b0;
    drop         = 4'b0000;
    for (int i = 0; i < 4; i++) left[i] = 0;

    ev[0] = '{4'b1111, {5'd2,  5'd2,  5'd2,  5'd2}, 4'b0000};
    ev[1] = '{4'b1111, {5'd16, 5'd17, 5'd0,  5'd1}, 4'b0110};
    ev[2] = '{4'b0101, {5'd0,  5'd0,  5'd0,  5'd0}, 4'b0101};
    ev[3] = '{4'b0000, {5'd0,  5'd0,  5'd0,  5'd0}, 4'b0000};
    ev[4] = '{4'b1010, {5'd31, 5'd3,  5'd16, 5'd0}, 4'b1000};

    // Per packet: WAIT_SPACE, two writes, mandatory IDLE.
    for (int p = 0; p < 4; p++) begin
      set_tr(4*p+0, 4'(1 << p), 4'b0000,    1'b0, 1'b1, 8'(8'hA0 + 8'h11*p));
      set_tr(4*p+1, 4'(1 << p), 4'(1 << p), 1'b1, 1'b1, 8'(8'hA0 + 8'h11*p));
      set_tr(4*p+2, 4'(1 << p), 4'(1 << p), 1'b1, 1'b1, 8'(8'hA0 + 8'h11*p));
      set_tr(4*p+3, 4'b0000,    4'b0000,    1'b0, 1'b0, 8'h00);
    end

    repeat (2) @(negedge clk);

    // Length decode and outputs while held in reset.
    for (int v = 0; v < 5; v++) begin
      bif.req     = ev[v].req;
      bif.req_len = ev[v].len;
      #1;
      check("err_len_vec", {28'd0, bif.err_len}, {28'd0, ev[v].err});
      check("reset_outs", {9'd0, bif.gnt, bif.ack, bif.wren, bif.busy, bif.abort,
                           bif.datain, bif.owner}, 32'd0);
      @(negedge clk);
    end
    bif.req     = 4'b0000;
    bif.req_len = '0;
    @(negedge clk);

    // All four requesting, len 2 each.
    reset_ = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_len(i, 5'd2);
      left[i] = 2;
    end
    bif.req = 4'b1111;
    for (int k = 0; k < 16; k++) begin
      step();
      check("rr_trace", {14'd0, s_gnt, s_ack, s_wren, s_busy, s_data},
            {14'd0, tr[k].gnt, tr[k].ack, tr[k].wren, tr[k].busy, tr[k].data});
    end

    // Waiting for FIFO space.
    n_wr = 0;
    set_len(2, 5'd5);
    bif.wrusedw = 5'd12;
    bif.req     = 4'b0100;
    left[2]     = 5;
    for (int c = 0; c < 6; c++) begin
      step();
      check("space_wait", {26'd0, s_gnt, s_wren, s_busy}, {26'd0, 4'b0100, 1'b0, 1'b1});
    end
    bif.wrusedw = 5'd11;
    step();
    check("space_first_wr", {23'd0, s_wren, s_data}, {23'd0, 1'b1, 8'hC2});
    wait_idle(20, "space");
    check("space_writes", n_wr, 32'd5);

    // Full-length packet with a two-cycle wrfull stall.
    n_wr = 0; n_stall = 0; stalled = 0;
    bif.wrusedw = '0;
    set_len(1, 5'd16);
    bif.req = 4'b0010;
    left[1] = 16;
    step();
    for (int c = 0; c < 60; c++) begin
      step();
      if (s_busy && !s_wren && n_wr > 0 && n_wr < 16) n_stall++;
      if (n_wr == 5 && stalled == 0) begin
        pend_full = 1'b1;
        stalled   = 1;
      end else if (stalled == 1) begin
        stalled = 2;
      end else if (stalled == 2) begin
        pend_full = 1'b0;
        stalled   = 3;
      end
      if (!s_busy) break;
    end
    check("stall_done", {31'd0, s_busy}, 32'd0);
    check("stall_cycles", n_stall, 32'd2);
    check("stall_writes", n_wr, 32'd16);

    // Invalid length is never granted.
    n_wr = 0; saw_bad = 1'b0;
    set_len(1, 5'd0);
    set_len(3, 5'd4);
    bif.req = 4'b1010;
    left[3] = 4;
    #1;
    check("bad_err_len", {28'd0, bif.err_len}, {28'd0, 4'b0010});
    for (int c = 0; c < 30; c++) begin
      step();
      if (s_gnt[1] || (s_busy && s_gnt != 4'b1000)) saw_bad = 1'b1;
      if (!s_busy && n_wr > 0) break;
    end
    check("bad_only_req3", {31'd0, saw_bad}, 32'd0);
    check("bad_writes", n_wr, 32'd4);
    bif.req[1] = 1'b0;

    // Requester 0 gives up after 2 of 6 words.
    n_wr = 0; n_ab = 0;
    set_len(0, 5'd6);
    bif.req = 4'b0001;
    left[0] = 2;
    for (int c = 0; c < 20; c++) begin
      step();
      if (s_abort) break;
    end
    check("abort_cycle", {30'd0, s_abort, s_wren}, {30'd0, 2'b10});
    step();
    check("abort_then_idle", {30'd0, s_busy, s_abort}, 32'd0);
    repeat (3) step();
    check("abort_pulses", n_ab, 32'd1);
    check("abort_writes", n_wr, 32'd2);

    // Asynchronous reset in the middle of a transfer.
    n_wr = 0;
    set_len(1, 5'd8);
    bif.req = 4'b0010;
    left[1] = 8;
    for (int c = 0; c < 20; c++) begin
      step();
      if (n_wr == 3) break;
    end
    check("rst_mid_xfer", {30'd0, s_wren, s_busy}, {30'd0, 2'b11});
    #2;
    reset_ = 1'b0;
    #1;
    check("rst_async", {22'd0, bif.wren, bif.gnt, bif.busy, bif.ack}, 32'd0);
    bif.req = 4'b0000;
    drop    = 4'b0000;
    for (int i = 0; i < 4; i++) left[i] = 0;
    step();
    check("rst_held", {29'd0, bif.owner, s_busy}, 32'd0);
    @(negedge clk);
    reset_ = 1'b1;
    n_wr   = 0;
    for (int i = 0; i < 4; i++) begin
      set_len(i, 5'd1);
      left[i] = 1;
    end
    bif.req = 4'b1111;
    step();
    check("rst_first_gnt", {28'd0, s_gnt}, {28'd0, 4'b0001});
    for (int c = 0; c < 30; c++) begin
      step();
      if (bif.req == 4'b0000 && !s_busy) break;
    end
    check("rst_writes", n_wr, 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter WIDTH, default 8: data word width, equal to the FIFO datain width.
REQ-002 Parameter DEPTH, default 16: FIFO depth in words.
REQ-003 Parameter PTR, default 4: log2(DEPTH); all count fields are PTR+1 bits wide.
REQ-004 clk  in  1: the single clock; all state changes on its rising edge.
REQ-005 reset_  in  1: asynchronous, active-low reset.
REQ-006 req  in  4: req[i] high = requester i has a packet pending; held high until its last ack.
REQ-007 req_len  in  4*(PTR+1): packet length in words, requester i at bits [i*(PTR+1) +: PTR+1]; stable while req[i] is high.
REQ-008 req_data  in  4*WIDTH: data word, requester i at bits [i*WIDTH +: WIDTH].
REQ-009 gnt  out  4: one-hot; gnt[i] high = requester i owns the FIFO write port.
REQ-010 ack  out  4: ack[i] high = the word on requester i's req_data is written this cycle.
REQ-011 wren  out  1: FIFO write enable.
REQ-012 datain  out  WIDTH: FIFO write data.
REQ-013 wrfull  in  1: FIFO full flag.
REQ-014 wrusedw  in  PTR+1: FIFO occupancy in words.
REQ-015 owner  out  2: index of the current or last owner.
REQ-016 busy  out  1: high in any state other than IDLE.
REQ-017 err_len  out  4: err_len[i] = req[i] & (len==0 | len>DEPTH), combinational.
REQ-018 abort  out  1: one-cycle pulse when a transfer is cut short.

Function
REQ-019 The state machine SHALL have states IDLE, WAIT_SPACE and XFER, held in registers.
REQ-020 Eligible requester: req[i]=1 with 1<=len<=DEPTH; requesters with an invalid length SHALL never be granted.
REQ-021 IDLE: if any requester is eligible, the winner SHALL be chosen round-robin, searching last_owner+1, +2, +3, +4 (mod 4). The winner's index SHALL be latched into owner and its len into rem (PTR+1 bits), and the state SHALL go to WAIT_SPACE.
REQ-022 gnt[owner] SHALL be high in WAIT_SPACE and XFER, and low in IDLE.
REQ-023 WAIT_SPACE: go to XFER when (DEPTH - wrusedw) >= rem and wrfull=0; otherwise stay.
REQ-024 WAIT_SPACE: if req[owner] drops, SHALL return to IDLE with no abort pulse.
REQ-025 XFER: wren = ack[owner] = !wrfull, combinational. datain SHALL be owner's req_data slice whenever gnt is high, and 0 otherwise.
REQ-026 XFER: each cycle with wren=1, rem SHALL decrement by 1.
REQ-027 XFER: when wren=1 and rem==1, the state SHALL go to IDLE and last_owner SHALL be set to owner.
REQ-028 XFER with wrfull=1: stall with wren=0, ack=0 and rem unchanged.
REQ-029 XFER: if req[owner]=0, there SHALL be no write that cycle; the state SHALL go to IDLE, abort SHALL pulse for 1 cycle, and last_owner SHALL be set to owner.
REQ-030 Latency: req is seen in IDLE at cycle N, gnt is asserted at N+1, and the first wren is asserted at N+2 at the earliest.
REQ-031 A packet of L words with no stalls SHALL produce exactly L consecutive wren cycles; there is no idle gap inside a packet.
REQ-032 ack and wren SHALL never be high outside XFER.
REQ-033 At most one ack bit SHALL ever be high.
REQ-034 There SHALL be one mandatory IDLE cycle between packets.
REQ-035 A requester re-asserting req after its own packet SHALL wait behind all other eligible requesters.

Reset
REQ-036 While reset_=0, regardless of clk: state=IDLE, owner=0, last_owner=3 (so requester 0 wins first), rem=0.
REQ-037 While reset_=0: gnt=0, ack=0, wren=0, datain=0, abort=0, busy=0.
REQ-038 Reset asserted mid-XFER SHALL drop wren immediately. No partial-packet recovery is performed; the FIFO is reset by the same reset_.

Verification
REQ-039 After reset, req=4'b1111 with all len=2 and wrusedw=0 -> grant order 0,1,2,3; wren high for 2 cycles per packet; 1 IDLE cycle between packets.
REQ-040 req[2] only, len=5, wrusedw=12 -> gnt[2] held in WAIT_SPACE with wren=0; when wrusedw<=11 -> 5 writes follow.
REQ-041 len=16, wrusedw=0, wrfull pulsed high for 2 cycles mid-packet -> wren/ack low for exactly those 2 cycles; 16 writes total.
REQ-042 req[1] len=0 and req[3] len=4 -> err_len=4'b0010; only requester 3 granted.
REQ-043 req[0] dropped after 2 of 6 words -> abort pulses once; state=IDLE the next cycle; exactly 2 writes.
REQ-044 reset_ asserted asynchronously mid-XFER -> wren, gnt and busy go to 0 without a clk edge; after release, requester 0 has first priority.
